// File: rtl/cond_logic.sv
// ----------------------------------------------------------------------------
// cond_logic
//
// Condition/flag stage of the single-cycle ARM datapath. It sits directly
// after the PC-select logic and does three things:
//   - Evaluates the instruction condition field against the NZCV register
//     that this block owns.
//   - Gates the decoder's raw write requests with that result.
//   - Captures new ALU flags only when the instruction actually executes.
//
// Optional feature, selected by the macro COND_BRCNT_EN:
//   Adds a saturating taken-branch counter (branch_count) with a
//   synchronous clear (cnt_clr). When the macro is undefined the counter
//   and both of its ports are absent.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   en           in   1      instruction valid / advance (0 = stall cycle)
//   Cond         in   4      instruction condition field, Instr[31:28]
//   ALUFlags     in   4      ALU flags {N,Z,C,V}
//   FlagW        in   2      [1] updates N,Z ; [0] updates C,V
//   PCS          in   1      PC-write request
//   RegW         in   1      register-write request
//   MemW         in   1      memory-write request
//   NoWrite      in   1      suppress register write (CMP/CMN/TST/TEQ)
//   PCSrc        out  1      PC takes the result
//   RegWrite     out  1      register file write enable
//   MemWrite     out  1      data memory write enable
//   CondEx       out  1      condition passed this cycle
//   Flags        out  4      registered NZCV, same bit order as ALUFlags
//   cnt_clr      in   1      synchronous counter clear   (COND_BRCNT_EN only)
//   branch_count out  CNT_W  saturating taken-branch count (COND_BRCNT_EN only)
// ----------------------------------------------------------------------------
module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags
`ifdef COND_BRCNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] branch_count
`endif
);

    // A zero-width counter makes no sense; stop elaboration early.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cond_logic: CNT_W must be at least 1");
    end

    logic [3:0] flags_cur;
    logic       cond_pass;
    logic       exec;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags_cur[3];
    assign flag_z = flags_cur[2];
    assign flag_c = flags_cur[1];
    assign flag_v = flags_cur[0];

    // The condition looks only at the registered flags. An instruction that
    // both tests and sets flags therefore sees the old NZCV, and its own
    // result becomes visible in the following cycle.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;  // 1111 is reserved and never executes
        endcase
    end

    // en is ANDed first so that an unknown Cond during a stall resolves to 0
    // and cannot disturb any state.
    assign exec = en & cond_pass;

    // The write enables are zero-latency. Reset masks them directly because
    // it is asynchronous and must take effect without waiting for a clock.
    assign CondEx   = ~reset & cond_pass;
    assign PCSrc    = ~reset & exec & PCS;
    assign RegWrite = ~reset & exec & RegW & ~NoWrite;
    assign MemWrite = ~reset & exec & MemW;

    // Flag register, held as two independent halves:
    //   half 1 = {N,Z}, written when FlagW[1] is set
    //   half 0 = {C,V}, written when FlagW[0] is set
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
        logic [1:0] flag_half_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                flag_half_reg <= 2'b00;
            end else if (exec && FlagW[gi]) begin
                flag_half_reg <= ALUFlags[2*gi+1 -: 2];
            end
        end
    end

    assign flags_cur = {g_flag[1].flag_half_reg, g_flag[0].flag_half_reg};
    assign Flags     = flags_cur;

`ifdef COND_BRCNT_EN
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Clear has priority over a simultaneous increment. The count sticks at
    // all-ones instead of wrapping. PCSrc already folds in en and the
    // condition result, so stalls and failed branches do not count.
    always_comb begin
        count_next = count_reg;
        if (cnt_clr) begin
            count_next = '0;
        end else if (PCSrc && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign branch_count = count_reg;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// ----------------------------------------------------------------------------
// tb_cond_logic
//
// Self-checking bench for cond_logic.
//   - A vector table covers the condition codes, the flag halves and the
//     write gating.
//   - Hand-written sequences cover:
//       * unknown Cond during a stall
//       * the taken-branch counter (COND_BRCNT_EN builds only)
//       * reset asserted in the middle of a cycle
//   - Expected results are queued when a vector is driven, then popped and
//     compared while the DUT presents its outputs.
// ----------------------------------------------------------------------------
module tb_cond_logic;

    localparam int TB_CNT_W = 2;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
    logic       cnt_clr;
`ifdef COND_BRCNT_EN
    logic [TB_CNT_W-1:0] branch_count;
`endif

    cond_logic #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .Cond         (Cond),
        .ALUFlags     (ALUFlags),
        .FlagW        (FlagW),
        .PCS          (PCS),
        .RegW         (RegW),
        .MemW         (MemW),
        .NoWrite      (NoWrite),
        .PCSrc        (PCSrc),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .CondEx       (CondEx),
        .Flags        (Flags)
`ifdef COND_BRCNT_EN
        ,
        .cnt_clr      (cnt_clr),
        .branch_count (branch_count)
`endif
    );

    // 10-unit clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One stimulus vector plus its expected results.
    typedef struct {
        logic       en;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowrite;
        logic       clr;
        logic       condex;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [3:0] flags;   // expected Flags after the clock edge
        int         cnt;     // expected count after the edge, -1 = not checked
    } vec_t;

    // What the scoreboard holds for one driven vector.
    typedef struct {
        logic       condex;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [3:0] flags;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic       en_i,
        input logic [3:0] cond_i,
        input logic [3:0] alu_i,
        input logic [1:0] flagw_i,
        input logic       pcs_i,
        input logic       regw_i,
        input logic       memw_i,
        input logic       nowrite_i,
        input logic       cx_i,
        input logic       ps_i,
        input logic       rw_i,
        input logic       mw_i,
        input logic [3:0] flags_i,
        input logic       clr_i,
        input int         cnt_i
    );
        vec_t v;
        v.en       = en_i;
        v.cond     = cond_i;
        v.alu      = alu_i;
        v.flagw    = flagw_i;
        v.pcs      = pcs_i;
        v.regw     = regw_i;
        v.memw     = memw_i;
        v.nowrite  = nowrite_i;
        v.clr      = clr_i;
        v.condex   = cx_i;
        v.pcsrc    = ps_i;
        v.regwrite = rw_i;
        v.memwrite = mw_i;
        v.flags    = flags_i;
        v.cnt      = cnt_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Timing of one transaction:
    //   negedge   drive the vector and queue its expected results
    //   +2        pop the expectation and check the combinational outputs
    //   posedge+1 check the registered flags (and the counter, if built in)
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        en       = v.en;
        Cond     = v.cond;
        ALUFlags = v.alu;
        FlagW    = v.flagw;
        PCS      = v.pcs;
        RegW     = v.regw;
        MemW     = v.memw;
        NoWrite  = v.nowrite;
        cnt_clr  = v.clr;
        e.condex   = v.condex;
        e.pcsrc    = v.pcsrc;
        e.regwrite = v.regwrite;
        e.memwrite = v.memwrite;
        e.flags    = v.flags;
        e.cnt      = v.cnt;
        exp_q.push_back(e);
        #2;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected one entry", tag);
        end else begin
            got = exp_q.pop_front();
            chk({tag, " CondEx"},   32'(CondEx),   32'(got.condex));
            chk({tag, " PCSrc"},    32'(PCSrc),    32'(got.pcsrc));
            chk({tag, " RegWrite"}, 32'(RegWrite), 32'(got.regwrite));
            chk({tag, " MemWrite"}, 32'(MemWrite), 32'(got.memwrite));
            @(posedge clk);
            #1;
            chk({tag, " Flags"}, 32'(Flags), 32'(got.flags));
`ifdef COND_BRCNT_EN
            if (got.cnt >= 0) chk({tag, " branch_count"}, 32'(branch_count), 32'(got.cnt));
`endif
            $display("%s en=%b cond=%h alu=%h flagw=%b -> condex=%b pcsrc=%b regwrite=%b memwrite=%b flags=%b",
                     tag, v.en, v.cond, v.alu, v.flagw, CondEx, PCSrc, RegWrite, MemWrite, Flags);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[28];
        vec_t cseq[9];

        // Rows run in order from reset; each row's expected Flags depends on
        // the rows before it.
        //             en cond   alu    flagw  pcs  rw   mw   now   cx   ps   rw   mw   flags   clr  cnt
        tbl[0]  = mk(1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 0, -1); // EQ, Z=0
        tbl[1]  = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0000, 0, -1); // AL branch
        tbl[2]  = mk(1, 4'hE, 4'h4, 2'b11, 0, 0, 0, 0,  1, 0, 0, 0,  4'b0100, 0, -1); // set Z
        tbl[3]  = mk(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0,  1, 0, 1, 0,  4'b0100, 0, -1); // EQ passes
        tbl[4]  = mk(1, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0,  0, 0, 0, 0,  4'b0100, 0, -1); // NE fails
        tbl[5]  = mk(1, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0,  1, 0, 0, 0,  4'b0000, 0, -1); // clear flags
        tbl[6]  = mk(1, 4'hE, 4'hF, 2'b01, 0, 0, 0, 0,  1, 0, 0, 0,  4'b0011, 0, -1); // C,V half only
        tbl[7]  = mk(1, 4'hE, 4'h8, 2'b10, 0, 0, 0, 0,  1, 0, 0, 0,  4'b1011, 0, -1); // N,Z half only
        tbl[8]  = mk(1, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0,  1, 0, 0, 0,  4'b1000, 0, -1); // leaves N=1
        tbl[9]  = mk(1, 4'hB, 4'h0, 2'b11, 0, 0, 1, 0,  1, 0, 0, 1,  4'b0000, 0, -1); // LT uses old flags
        tbl[10] = mk(1, 4'hE, 4'h8, 2'b11, 0, 0, 0, 0,  1, 0, 0, 0,  4'b1000, 0, -1); // restore N=1
        tbl[11] = mk(1, 4'hA, 4'h0, 2'b11, 0, 0, 1, 0,  0, 0, 0, 0,  4'b1000, 0, -1); // GE fails, flags hold
        tbl[12] = mk(0, 4'hE, 4'h6, 2'b11, 1, 1, 1, 0,  1, 0, 0, 0,  4'b1000, 0, -1); // stall
        tbl[13] = mk(0, 4'hE, 4'h6, 2'b11, 1, 1, 1, 0,  1, 0, 0, 0,  4'b1000, 0, -1); // stall
        tbl[14] = mk(0, 4'hE, 4'h6, 2'b11, 1, 1, 1, 0,  1, 0, 0, 0,  4'b1000, 0, -1); // stall
        tbl[15] = mk(1, 4'hE, 4'h6, 2'b11, 0, 1, 0, 1,  1, 0, 0, 0,  4'b0110, 0, -1); // NoWrite
        // Flags now 0110: Z=1, C=1, N=0, V=0.
        tbl[16] = mk(1, 4'h8, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0110, 0, -1); // HI
        tbl[17] = mk(1, 4'h9, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, -1); // LS
        tbl[18] = mk(1, 4'hC, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0110, 0, -1); // GT
        tbl[19] = mk(1, 4'hD, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, -1); // LE
        tbl[20] = mk(1, 4'hF, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0110, 0, -1); // reserved
        tbl[21] = mk(1, 4'h2, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, -1); // CS
        tbl[22] = mk(1, 4'h3, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0110, 0, -1); // CC
        tbl[23] = mk(1, 4'h4, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0110, 0, -1); // MI
        tbl[24] = mk(1, 4'h5, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, -1); // PL
        tbl[25] = mk(1, 4'h6, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0110, 0, -1); // VS
        tbl[26] = mk(1, 4'h7, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, -1); // VC
        tbl[27] = mk(1, 4'hF, 4'hF, 2'b11, 0, 1, 0, 0,  0, 0, 0, 0,  4'b0110, 0, -1); // reserved, no flag write

        // Counter sequence. Flags stay 0110 because FlagW is 0 throughout.
        cseq[0] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 1, 0); // clear wins
        cseq[1] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, 1);
        cseq[2] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, 2);
        cseq[3] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, 3);
        cseq[4] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, 3); // saturated
        cseq[5] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, 3); // saturated
        cseq[6] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 1, 0); // clear vs taken
        cseq[7] = mk(0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 0, 0, 0,  4'b0110, 0, 0); // stall holds
        cseq[8] = mk(1, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0110, 0, 1);

        // Reset state
        reset    = 1'b1;
        en       = 1'b1;
        Cond     = 4'hE;
        ALUFlags = 4'h0;
        FlagW    = 2'b00;
        PCS      = 1'b1;
        RegW     = 1'b1;
        MemW     = 1'b1;
        NoWrite  = 1'b0;
        cnt_clr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset Flags",    32'(Flags),    32'h0);
        chk("reset PCSrc",    32'(PCSrc),    32'h0);
        chk("reset RegWrite", 32'(RegWrite), 32'h0);
        chk("reset MemWrite", 32'(MemWrite), 32'h0);
        chk("reset CondEx",   32'(CondEx),   32'h0);
`ifdef COND_BRCNT_EN
        chk("reset branch_count", 32'(branch_count), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 28; i++) step(tbl[i], $sformatf("row%0d", i));

        // Unknown Cond during a stall must leave everything alone.
        @(negedge clk);
        en       = 1'b0;
        Cond     = 4'bxxxx;
        ALUFlags = 4'hF;
        FlagW    = 2'b11;
        PCS      = 1'b1;
        RegW     = 1'b1;
        MemW     = 1'b1;
        NoWrite  = 1'b0;
        #2;
        chk("xcond PCSrc",    32'(PCSrc),    32'h0);
        chk("xcond RegWrite", 32'(RegWrite), 32'h0);
        chk("xcond MemWrite", 32'(MemWrite), 32'h0);
        @(posedge clk);
        #1;
        chk("xcond Flags", 32'(Flags), 32'h6);
        $display("xcond en=0 cond=x -> flags=%b", Flags);

`ifdef COND_BRCNT_EN
        for (int i = 0; i < 9; i++) step(cseq[i], $sformatf("cnt%0d", i));
`endif

        // Reset asserted mid-cycle: state clears before the next edge.
        @(negedge clk);
        en      = 1'b1;
        Cond    = 4'hE;
        FlagW   = 2'b00;
        PCS     = 1'b1;
        RegW    = 1'b1;
        MemW    = 1'b1;
        cnt_clr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst Flags",    32'(Flags),    32'h0);
        chk("midrst PCSrc",    32'(PCSrc),    32'h0);
        chk("midrst RegWrite", 32'(RegWrite), 32'h0);
        chk("midrst MemWrite", 32'(MemWrite), 32'h0);
        chk("midrst CondEx",   32'(CondEx),   32'h0);
`ifdef COND_BRCNT_EN
        chk("midrst branch_count", 32'(branch_count), 32'h0);
`endif
        $display("midrst reset=1 -> flags=%b pcsrc=%b", Flags, PCSrc);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // The first cycles after release evaluate against NZCV=0000.
        step(mk(1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0,  0, 0, 0, 0,  4'b0000, 0, 0), "post0");
        step(mk(1, 4'h1, 4'h0, 2'b00, 1, 0, 0, 0,  1, 1, 0, 0,  4'b0000, 0, 1), "post1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Condition/flag stage directly downstream of the PC-select logic in the single-cycle ARM datapath.
- Consumes the decoder's raw PCS, RegW, MemW and NoWrite requests and gates them with the instruction's condition field, evaluated against the architectural NZCV flag register this block owns.
- Drives the final PCSrc, RegWrite and MemWrite to the PC mux, register file and data memory.
- Updates flags from the ALU only when the instruction executes.

Parameters:
- CNT_W, 16, width of the taken-branch counter (used only with COND_BRCNT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  instruction-valid/advance; low = stall cycle.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags {N,Z,C,V}; [3]=N, [2]=Z, [1]=C, [0]=V.
- FlagW  in  2  flag-write request; [1] updates N,Z; [0] updates C,V.
- PCS  in  1  PC-write request from PC logic.
- RegW  in  1  register-write request from decoder.
- MemW  in  1  memory-write request from decoder.
- NoWrite  in  1  suppress register write (CMP/CMN/TST/TEQ).
- PCSrc  out  1  PC takes result.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- CondEx  out  1  condition passed this cycle.
- Flags  out  4  registered NZCV, same bit order as ALUFlags.
- cnt_clr  in  1  synchronous counter clear (present only with COND_BRCNT_EN).
- branch_count  out  CNT_W  taken-branch count (present only with COND_BRCNT_EN).

Behaviour:
- Reset (asynchronous, active-high):
  - Flags = 4'b0000.
  - PCSrc, RegWrite, MemWrite and CondEx are forced to 0 while reset is high.
  - branch_count = 0.
- CondEx is combinational from Cond and the registered Flags, never from the current ALUFlags. Mapping:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (reserved, never executes)
- Outputs (combinational, same cycle, zero latency):
  - PCSrc = en & CondEx & PCS.
  - RegWrite = en & CondEx & RegW & ~NoWrite.
  - MemWrite = en & CondEx & MemW.
- Flag register:
  - At rising clk, when en & CondEx & FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - At rising clk, when en & CondEx & FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - Halves update independently.
  - Failed condition or en=0: Flags hold.
- Instruction that both tests and sets flags: evaluates on old Flags; new Flags are visible from the next cycle.
- Stall (en=0): all write enables 0; Flags and counter hold. CondEx still reflects Cond/Flags.
- Reset mid-operation: flags cleared immediately, without waiting for clk. The first cycle after release evaluates against NZCV=0000.
- X on Cond while en=0 must not disturb state.

Optional Feature:
- Macro: COND_BRCNT_EN.
- Defined:
  - Adds ports cnt_clr and branch_count.
  - Counter increments at rising clk when PCSrc=1.
  - Saturates at all-ones (no wrap).
  - cnt_clr=1 loads 0 and wins over a simultaneous increment.
  - Counter is cleared by reset.
- Undefined: ports, counter register and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then Cond=0000 (EQ), PCS=1, en=1 -> CondEx=0, PCSrc=0. Cond=1110 -> PCSrc=1.
- ALUFlags=4'b0100, FlagW=2'b11, Cond=1110, en=1, one clk -> Flags=4'b0100. Next cycle Cond=0000, RegW=1 -> RegWrite=1. Cond=0001 -> RegWrite=0.
- Flags=0000; apply FlagW=2'b01 with ALUFlags=4'b1111 -> Flags=4'b0011 (N,Z unchanged). Then FlagW=2'b10 with ALUFlags=4'b1000 -> Flags=4'b1011.
- Flags=1000 (N=1,V=0), Cond=1011 (LT), FlagW=2'b11, ALUFlags=0000, MemW=1 -> MemWrite=1 this cycle, Flags=0000 after clk. Same with Cond=1010 (GE) -> MemWrite=0, Flags stay 1000.
- en=0 with Cond=1110, PCS=RegW=MemW=1, FlagW=11 -> all enables 0, Flags unchanged over 3 clks. NoWrite=1 with en=1 -> RegWrite=0, flags still update.
- COND_BRCNT_EN, CNT_W=2:
  - 5 taken branches -> branch_count=3 (saturated).
  - cnt_clr together with a taken branch -> 0.
  - reset asserted mid-cycle -> count 0 and Flags 0000 before the next edge.
